// File: rtl/register_file_requester.sv
// register_file_requester: initiator for one read/write port of the
// multi-port register file. Turns binary-addressed requests into a one-hot
// register select plus write strobe, captures read data after READ_LATENCY
// cycles and returns one response per request.
//
// Optional build macro: REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
//   defined   -> out-of-range addresses skip the port access and answer
//                with rsp_err_o = 1, rsp_data_o = 0 one cycle later.
//   undefined -> rsp_err_o tied 0; out-of-range addresses run the normal
//                path with an all-zero select.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request, port selects idle
// ST_ISSUE | first select cycle; write strobe asserted for writes
// ST_WAIT  | read only: select held while read data settles
// ST_RESP  | response valid, held until rsp_ready_i

module register_file_requester #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 3,
  parameter int ADDR_WIDTH    = 2,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic                     rsp_write_o,
  output logic                     rsp_err_o,
  output logic [NUM_REGISTERS-1:0] register_select_o,
  output logic                     write_select_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  input  logic [DATA_WIDTH-1:0]    data_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    port_active;
  logic [NUM_REGISTERS-1:0] sel_onehot;

`ifdef REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
  logic err_q, err_d;
  logic addr_oob;

  // Addresses past the last register are answered without touching the port.
  always_comb begin
    addr_oob = (32'(req_addr_i) >= 32'(NUM_REGISTERS));
  end
`endif

  // State and transaction registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      cnt_q      <= 3'd0;
`ifdef REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
`ifdef REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  // Next-state logic: one transaction at a time, read data captured on the
  // last cycle of the select window.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
`ifdef REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          data_d  = req_data_i;
`ifdef REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
          if (addr_oob) begin
            err_d      = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        if (write_q) begin
          rsp_data_d = data_q;
          state_d    = ST_RESP;
        end else if (READ_LATENCY == 0) begin
          rsp_data_d = data_i;
          state_d    = ST_RESP;
        end else begin
          cnt_d   = 3'(READ_LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          rsp_data_d = data_i;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One-hot decode of the latched address; out-of-range decodes to all zero.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      sel_onehot[i] = (32'(addr_q) == 32'(i));
    end
  end

  // Port drive is gated to the select window so the register file sees an
  // idle port at all other times.
  always_comb begin
    port_active       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    register_select_o = port_active ? sel_onehot : '0;
    write_select_o    = (state_q == ST_ISSUE) && write_q;
    data_o            = port_active ? data_q : '0;
  end

  // Handshake and response outputs.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
    rsp_data_o  = rsp_data_q;
    rsp_write_o = write_q;
`ifdef REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
    rsp_err_o   = err_q;
`else
    rsp_err_o   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_register_file_requester.sv
// Bench for register_file_requester: instance A uses READ_LATENCY = 1 with a
// registered read-data model, instance B uses READ_LATENCY = 0 with a
// combinational read-data model. Expected responses go through a queue.
module tb_register_file_requester;

  typedef struct packed {
    logic [31:0] data;
    logic        write;
    logic        err;
  } rsp_t;

  localparam logic [31:0] NOSEL = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic model_clr = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid_a = 0, req_write_a = 0, rsp_ready_a = 0;
  logic [1:0]  req_addr_a = 0;
  logic [31:0] req_data_a = 0;
  logic        req_ready_a, rsp_valid_a, rsp_write_a, rsp_err_a, wsel_a;
  logic [31:0] rsp_data_a, data_o_a, data_i_a;
  logic [2:0]  sel_a;

  logic        req_valid_b = 0, req_write_b = 0, rsp_ready_b = 0;
  logic [1:0]  req_addr_b = 0;
  logic [31:0] req_data_b = 0;
  logic        req_ready_b, rsp_valid_b, rsp_write_b, rsp_err_b, wsel_b;
  logic [31:0] rsp_data_b, data_o_b, data_i_b;
  logic [2:0]  sel_b;

  register_file_requester #(.DATA_WIDTH(32), .NUM_REGISTERS(3), .ADDR_WIDTH(2), .READ_LATENCY(1)) u_dut_a (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_write_i(req_write_a),
    .req_addr_i(req_addr_a), .req_data_i(req_data_a),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a), .rsp_data_o(rsp_data_a),
    .rsp_write_o(rsp_write_a), .rsp_err_o(rsp_err_a),
    .register_select_o(sel_a), .write_select_o(wsel_a), .data_o(data_o_a), .data_i(data_i_a)
  );

  register_file_requester #(.DATA_WIDTH(32), .NUM_REGISTERS(3), .ADDR_WIDTH(2), .READ_LATENCY(0)) u_dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_write_i(req_write_b),
    .req_addr_i(req_addr_b), .req_data_i(req_data_b),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b), .rsp_data_o(rsp_data_b),
    .rsp_write_o(rsp_write_b), .rsp_err_o(rsp_err_b),
    .register_select_o(sel_b), .write_select_o(wsel_b), .data_o(data_o_b), .data_i(data_i_b)
  );

  // Register file models
  logic [2:0][31:0] rf_a, rf_b, shadow_a;
  logic [31:0]      rdata_a;

  function automatic logic [31:0] lookup(input logic [2:0][31:0] rf, input logic [2:0] sel);
    logic [31:0] r;
    r = NOSEL;
    for (int i = 0; i < 3; i++) if (sel[i]) r = rf[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (model_clr) begin
      rf_a <= {32'h0000_0000, 32'h1234_5678, 32'h1111_1111};
      rf_b <= '0;
    end else begin
      if (wsel_a) for (int i = 0; i < 3; i++) if (sel_a[i]) rf_a[i] <= data_o_a;
      if (wsel_b) for (int i = 0; i < 3; i++) if (sel_b[i]) rf_b[i] <= data_o_b;
    end
    rdata_a <= lookup(rf_a, sel_a);
  end
  assign data_i_a = rdata_a;
  assign data_i_b = lookup(rf_b, sel_b);

  int checks = 0;
  int errors = 0;
  rsp_t exp_a[$];
  rsp_t exp_b[$];

  task automatic send_req(input int inst, input logic w, input logic [1:0] addr, input logic [31:0] data);
    bit done = 0;
    if (inst == 0) begin req_valid_a = 1; req_write_a = w; req_addr_a = addr; req_data_a = data; end
    else begin req_valid_b = 1; req_write_b = w; req_addr_b = addr; req_data_b = data; end
    for (int c = 0; c < 20 && !done; c++) begin
      if ((inst == 0) ? req_ready_a : req_ready_b) done = 1;
      @(negedge clk);
    end
    req_valid_a = 0; req_valid_b = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL req_timeout inst %0d: req_ready never seen", inst);
    end
  endtask

  task automatic collect(input int inst, input int max_cycles);
    bit got = 0;
    rsp_t e, a;
    for (int c = 0; c < max_cycles && !got; c++) begin
      if ((inst == 0) ? rsp_valid_a : rsp_valid_b) begin
        got = 1;
        a = (inst == 0) ? '{rsp_data_a, rsp_write_a, rsp_err_a} : '{rsp_data_b, rsp_write_b, rsp_err_b};
        checks++;
        if (((inst == 0) ? exp_a.size() : exp_b.size()) == 0) begin
          errors++;
          $display("FAIL rsp_unexpected inst %0d: got data %h", inst, a.data);
        end else begin
          e = (inst == 0) ? exp_a.pop_front() : exp_b.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL rsp inst %0d: got data %h write %b err %b, expected data %h write %b err %b",
                     inst, a.data, a.write, a.err, e.data, e.write, e.err);
          end
        end
        if (inst == 0) rsp_ready_a = 1; else rsp_ready_b = 1;
        @(negedge clk);
        rsp_ready_a = 0; rsp_ready_b = 0;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rsp_timeout inst %0d: no rsp_valid within %0d cycles", inst, max_cycles);
    end
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b expected 1", req_ready_a); end
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid_a); end
    checks++; if ({sel_a, wsel_a, data_o_a} !== 36'h0) begin errors++; $display("FAIL reset_port got %h expected 0", {sel_a, wsel_a, data_o_a}); end
    checks++; if ({rsp_data_a, rsp_write_a, rsp_err_a} !== 34'h0) begin errors++; $display("FAIL reset_rsp_fields got %h expected 0", {rsp_data_a, rsp_write_a, rsp_err_a}); end
    checks++; if ({req_ready_b, rsp_valid_b, sel_b, wsel_b} !== 6'b100000) begin errors++; $display("FAIL reset_b got %b expected 100000", {req_ready_b, rsp_valid_b, sel_b, wsel_b}); end
    model_clr = 0;
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_write;
    req_valid_a = 1; req_write_a = 1; req_addr_a = 2; req_data_a = 32'hDEAD_BEEF;
    checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL wr_ready got %b expected 1", req_ready_a); end
    exp_a.push_back('{32'hDEAD_BEEF, 1'b1, 1'b0});
    shadow_a[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid_a = 0;
    checks++; if (sel_a !== 3'b100) begin errors++; $display("FAIL wr_sel got %b expected 100", sel_a); end
    checks++; if (wsel_a !== 1'b1) begin errors++; $display("FAIL wr_strobe got %b expected 1", wsel_a); end
    checks++; if (data_o_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_data_o got %h expected deadbeef", data_o_a); end
    checks++; if ({rsp_valid_a, req_ready_a} !== 2'b00) begin errors++; $display("FAIL wr_issue_hs got %b expected 00", {rsp_valid_a, req_ready_a}); end
    @(negedge clk);
    checks++; if ({rsp_valid_a, rsp_write_a} !== 2'b11) begin errors++; $display("FAIL wr_rsp_timing got %b expected 11", {rsp_valid_a, rsp_write_a}); end
    checks++; if ({sel_a, wsel_a} !== 4'b0000) begin errors++; $display("FAIL wr_port_idle got %b expected 0000", {sel_a, wsel_a}); end
    collect(0, 2);
  endtask

  task automatic test_read;
    req_valid_a = 1; req_write_a = 0; req_addr_a = 1; req_data_a = 32'h0;
    exp_a.push_back('{32'h1234_5678, 1'b0, 1'b0});
    @(negedge clk);
    req_valid_a = 0;
    checks++; if ({sel_a, wsel_a} !== 4'b0100) begin errors++; $display("FAIL rd_sel1 got %b expected 0100", {sel_a, wsel_a}); end
    @(negedge clk);
    checks++; if ({sel_a, rsp_valid_a} !== 4'b0100) begin errors++; $display("FAIL rd_sel2 got %b expected 0100", {sel_a, rsp_valid_a}); end
    @(negedge clk);
    checks++; if ({sel_a, rsp_valid_a} !== 4'b0001) begin errors++; $display("FAIL rd_rsp_timing got %b expected 0001", {sel_a, rsp_valid_a}); end
    collect(0, 2);
  endtask

  task automatic test_backpressure;
    bit seen = 0;
    exp_a.push_back('{shadow_a[2], 1'b0, 1'b0});
    send_req(0, 1'b0, 2'd2, 32'h0);
    for (int c = 0; c < 6 && !seen; c++) begin
      if (rsp_valid_a) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_rsp_timeout got no rsp_valid expected 1"); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({rsp_valid_a, req_ready_a, rsp_data_a} !== {2'b10, shadow_a[2]}) begin
        errors++; $display("FAIL bp_hold cycle %0d got %b %b %h expected 1 0 %h", c, rsp_valid_a, req_ready_a, rsp_data_a, shadow_a[2]);
      end
      @(negedge clk);
    end
    collect(0, 2);
    checks++; if ({rsp_valid_a, req_ready_a} !== 2'b01) begin errors++; $display("FAIL bp_idle got %b expected 01", {rsp_valid_a, req_ready_a}); end
  endtask

  task automatic test_reset_mid;
    req_valid_a = 1; req_write_a = 0; req_addr_a = 1;
    @(negedge clk);
    req_valid_a = 0;
    @(negedge clk);
    checks++; if (sel_a !== 3'b010) begin errors++; $display("FAIL rst_mid_wait_sel got %b expected 010", sel_a); end
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    checks++; if ({sel_a, wsel_a, rsp_valid_a, req_ready_a} !== 6'b000001) begin errors++; $display("FAIL rst_mid_state got %b expected 000001", {sel_a, wsel_a, rsp_valid_a, req_ready_a}); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp cycle %0d got %b expected 0", c, rsp_valid_a); end
      @(negedge clk);
    end
  endtask

  task automatic test_out_of_range;
    for (int w = 0; w < 2; w++) begin
`ifdef REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
      exp_a.push_back('{32'h0, w[0], 1'b1});
`else
      exp_a.push_back('{(w == 1) ? 32'hCAFE_0003 : NOSEL, w[0], 1'b0});
`endif
      req_valid_a = 1; req_write_a = w[0]; req_addr_a = 3; req_data_a = 32'hCAFE_0003;
      @(negedge clk);
      req_valid_a = 0;
      checks++; if (sel_a !== 3'b000) begin errors++; $display("FAIL oob_sel w%0d got %b expected 000", w, sel_a); end
`ifdef REGISTER_FILE_REQUESTER_ADDR_CHECK_EN
      checks++; if ({wsel_a, rsp_valid_a, rsp_err_a} !== 3'b011) begin errors++; $display("FAIL oob_err_rsp w%0d got %b expected 011", w, {wsel_a, rsp_valid_a, rsp_err_a}); end
`else
      checks++; if ({wsel_a, rsp_valid_a} !== {w[0], 1'b0}) begin errors++; $display("FAIL oob_path w%0d got %b expected %b0", w, {wsel_a, rsp_valid_a}, w[0]); end
`endif
      collect(0, 5);
    end
    checks++; if (rf_a !== shadow_a) begin errors++; $display("FAIL oob_rf_unchanged got %h expected %h", rf_a, shadow_a); end
  endtask

  task automatic test_back_to_back;
    logic w;
    logic [1:0] addr;
    logic [31:0] data;
    for (int t = 0; t < 12; t++) begin
      w = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 2));
      data = $urandom;
      if (w) begin
        exp_a.push_back('{data, 1'b1, 1'b0});
        shadow_a[addr] = data;
      end else begin
        exp_a.push_back('{shadow_a[addr], 1'b0, 1'b0});
      end
      send_req(0, w, addr, data);
      collect(0, 8);
    end
  endtask

  task automatic test_rl0;
    req_valid_b = 1; req_write_b = 1; req_addr_b = 0; req_data_b = 32'hA5;
    exp_b.push_back('{32'hA5, 1'b1, 1'b0});
    @(negedge clk);
    req_valid_b = 0;
    checks++; if ({sel_b, wsel_b} !== 4'b0011) begin errors++; $display("FAIL rl0_wr_port got %b expected 0011", {sel_b, wsel_b}); end
    @(negedge clk);
    collect(1, 2);
    req_valid_b = 1; req_write_b = 0; req_addr_b = 0; req_data_b = 32'h0;
    exp_b.push_back('{32'hA5, 1'b0, 1'b0});
    @(negedge clk);
    req_valid_b = 0;
    checks++; if ({sel_b, wsel_b, rsp_valid_b} !== 5'b00100) begin errors++; $display("FAIL rl0_rd_port got %b expected 00100", {sel_b, wsel_b, rsp_valid_b}); end
    @(negedge clk);
    checks++; if (rsp_valid_b !== 1'b1) begin errors++; $display("FAIL rl0_rd_timing got %b expected 1", rsp_valid_b); end
    collect(1, 2);
  endtask

  initial begin
    shadow_a = {32'h0000_0000, 32'h1234_5678, 32'h1111_1111};
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_reset_mid();
    test_out_of_range();
    test_back_to_back();
    test_rl0();
    checks++;
    if (exp_a.size() + exp_b.size() != 0) begin
      errors++; $display("FAIL leftover_expected got %0d expected 0", exp_a.size() + exp_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file_requester.md
Name: register_file_requester

Overview:
- Initiator for one read/write port of the multi-port register file.
- Accepts binary-addressed read/write requests on a valid/ready channel and drives the port's one-hot register select, write select and write data.
- Captures read data after a fixed latency and returns a response on a second valid/ready channel.
- One instance per register-file port; one outstanding transaction per instance.

Parameters:
- DATA_WIDTH, 32, width of register data.
- NUM_REGISTERS, 3, number of registers; register select width.
- ADDR_WIDTH, 2, request address width; must be >= clog2(NUM_REGISTERS), minimum 1.
- READ_LATENCY, 1, cycles from first select cycle to valid read data on data_i; range 0..7.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_n_i  in  1  synchronous reset, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  binary register index.
- req_data_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_data_o  out  DATA_WIDTH  read data, or echoed write data.
- rsp_write_o  out  1  response belongs to a write.
- rsp_err_o  out  1  address error (see Optional Feature).
- register_select_o  out  NUM_REGISTERS  one-hot select to register file port.
- write_select_o  out  1  write strobe to register file port.
- data_o  out  DATA_WIDTH  write data to register file port.
- data_i  in  DATA_WIDTH  read data from register file port.

Behaviour:
- Clock and reset: single clock clk_i; reset_n_i is synchronous and active-low.
- Reset values: state IDLE; all outputs 0 except req_ready_o = 1.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - On handshake, latch write, addr and data, then go to ISSUE.
  - req_ready_o is 0 in every other state; no pipelining.
- ISSUE (1 cycle):
  - register_select_o = 1 << addr; data_o = latched data.
  - write_select_o = 1 only for a write.
  - Write: go to RESP; rsp_data_o = latched write data.
  - Read, READ_LATENCY = 0: capture data_i at the end of this cycle, then go to RESP.
  - Read, READ_LATENCY > 0: go to WAIT.
- WAIT (read only, READ_LATENCY cycles):
  - register_select_o held; write_select_o = 0.
  - 3-bit counter counts down.
  - data_i is captured at the end of the last WAIT cycle, then go to RESP.
- Outside ISSUE and WAIT: register_select_o, write_select_o and data_o are all 0.
- RESP:
  - rsp_valid_o = 1; rsp_data_o, rsp_write_o and rsp_err_o are held stable while rsp_ready_i = 0.
  - On rsp handshake, go to IDLE; rsp_valid_o drops next cycle.
  - A new request may be accepted one cycle later, not in the same cycle.
- Latencies:
  - Read, READ_LATENCY = 1: request handshake in cycle N, select in N+1 and N+2, rsp_valid_o rises in N+3.
  - Write: handshake in N, write strobe in N+1, rsp_valid_o in N+2.
- Reset mid-transaction: return to IDLE next edge, in-flight request dropped, no response, selects deasserted.
- Address 0..NUM_REGISTERS-1 always legal; out-of-range behaviour is defined under Optional Feature.

Optional Feature:
- Macro: REGISTER_FILE_REQUESTER_ADDR_CHECK_EN.
- Defined:
  - req_addr_i >= NUM_REGISTERS skips ISSUE and WAIT and goes IDLE -> RESP directly.
  - No select or write strobe is asserted.
  - Response has rsp_err_o = 1 and rsp_data_o = 0, available 1 cycle after handshake.
- Undefined:
  - rsp_err_o tied 0.
  - Out-of-range address follows the normal path with register_select_o all-zero and write_select_o still asserted for writes (no register changes).
  - Read response returns whatever data_i carries.

Test Plan:
- Write addr 2, data 0xDEADBEEF -> one cycle with register_select_o = 3'b100, write_select_o = 1, data_o = 0xDEADBEEF; rsp_valid_o next cycle with rsp_write_o = 1.
- Read addr 1, data_i = 0x12345678 from model with READ_LATENCY = 1 -> register_select_o = 3'b010 for 2 cycles; rsp_data_o = 0x12345678 three cycles after handshake.
- Hold rsp_ready_i = 0 for 5 cycles during a read response -> rsp_valid_o and rsp_data_o stable, req_ready_o = 0, then IDLE after handshake.
- Assert reset_n_i = 0 in WAIT -> next cycle all selects 0, rsp_valid_o = 0, req_ready_o = 1; no response emitted.
- With macro, read addr 3 (NUM_REGISTERS = 3) -> no select asserted, rsp_err_o = 1, rsp_data_o = 0 one cycle after handshake.
- READ_LATENCY = 0 back-to-back write addr 0 = 0xA5, then read addr 0 -> read response 0xA5.
